// File: rtl/alu_arbiter.sv
// Purpose : shares one ALU between port 0 (integer execute) and port 1 (address/branch gen),
//           round-robin on contention, one op in flight, with timeout, illegal-op reject and flush.
// Latency : accept -> rsp valid 2 cycles (1-cycle ALU), 1 cycle for illegal op; 4 cycles/op back-to-back.
// Backpr. : new requests stall (reqN_ready=0) until the owner consumes the response; rsp_* held meanwhile.
// Ports   : clk/rst (async active-high), flush; req{0,1}_{valid,ready,op,a,b}; rsp{0,1}_{valid,ready};
//           rsp_data/rsp_flags{Z,G,L}/rsp_err (shared); alu_en/alu_op/alu_a/alu_b to the ALU;
//           alu_data/alu_valid/alu_z/alu_g/alu_l from the ALU; busy (not idle).
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 5,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic             alu_en,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             alu_valid,
  input  logic             alu_z,
  input  logic             alu_g,
  input  logic             alu_l,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [OPW-1:0] OP_MIN = OPW'(1);
  localparam logic [OPW-1:0] OP_MAX = OPW'(20);

  logic [1:0]       state;
  logic             last_grant;  // port granted most recently; the other port wins a tie
  logic             owner;       // port whose op is in flight
  logic [CW-1:0]    wait_cnt;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             op_legal;
  logic             owner_rsp_ready;

  // Grants are mutually exclusive by construction: a tie resolves on last_grant.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = ~rst & (state == S_IDLE) & ~flush & grant0;
  assign req1_ready = ~rst & (state == S_IDLE) & ~flush & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_op   = grant1 ? req1_op : req0_op;
  assign sel_a    = grant1 ? req1_a  : req0_a;
  assign sel_b    = grant1 ? req1_b  : req0_b;
  assign op_legal = (sel_op >= OP_MIN) && (sel_op <= OP_MAX);

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state == S_RESP) & ~owner;
  assign rsp1_valid = (state == S_RESP) &  owner;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      alu_en     <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data   <= '0;
      rsp_flags  <= 3'b000;
      rsp_err    <= 1'b0;
    end else begin
      // alu_en is only ever a single-cycle pulse covering the ISSUE state.
      alu_en <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              owner      <= grant1;
              last_grant <= grant1;
              alu_op     <= sel_op;
              alu_a      <= sel_a;
              alu_b      <= sel_b;
              if (op_legal) begin
                alu_en <= 1'b1;
                state  <= S_ISSUE;
              end else begin
                rsp_data  <= '0;
                rsp_flags <= 3'b000;
                rsp_err   <= 1'b1;
                state     <= S_RESP;
              end
            end
          end
          S_ISSUE: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (alu_valid) begin
              rsp_data  <= alu_data;
              rsp_flags <= {alu_z, alu_g, alu_l};
              rsp_err   <= 1'b0;
              state     <= S_RESP;
            end else if (wait_cnt == TMO) begin
              // TIMEOUT+1 WAIT cycles without a result
              rsp_data  <= '0;
              rsp_flags <= 3'b000;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_RESP: begin
            if (owner_rsp_ready) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a simple 1-cycle ALU responder.
// Opcodes used by the responder: 01 add, 03 sub, 05 mul, 0D xor, other legal ops pass a through.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_data;
  logic        alu_valid;
  logic        alu_z, alu_g, alu_l;
  logic        busy;

  // ALU responder
  logic        alu_dead = 1'b0;   // when set, the ALU never answers
  logic        inj_valid = 1'b0;  // stray valid pulse injected by the bench
  logic        model_valid = 1'b0;
  logic [31:0] model_data = '0;
  logic        model_z = 1'b0, model_g = 1'b0, model_l = 1'b0;
  int          en_cnt = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OPW(5), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data), .alu_valid(alu_valid), .alu_z(alu_z), .alu_g(alu_g), .alu_l(alu_l),
    .busy(busy)
  );

  function automatic logic [31:0] alu_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'h01:   return a + b;
      5'h03:   return a - b;
      5'h05:   return a * b;
      5'h0D:   return a ^ b;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    model_valid <= alu_en && !alu_dead;
    if (alu_en) begin
      model_data <= alu_calc(alu_op, alu_a, alu_b);
      model_z    <= (alu_calc(alu_op, alu_a, alu_b) == 32'd0);
      model_g    <= (alu_a > alu_b);
      model_l    <= (alu_a < alu_b);
      en_cnt     <= en_cnt + 1;
    end
  end

  assign alu_valid = model_valid | inj_valid;
  assign alu_data  = model_data;
  assign alu_z     = model_z;
  assign alu_g     = model_g;
  assign alu_l     = model_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction on a single port with an always-ready consumer.
  task automatic run_op(input string tag, input logic port, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d,
                        input logic [2:0] exp_f, input logic exp_e);
    int n;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    check({tag, "_ready"}, 32'(port ? req1_ready : req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!(port ? rsp1_valid : rsp0_valid) && n < 40) begin tick(); n++; end
    check({tag, "_rsp_port"}, 32'({rsp1_valid, rsp0_valid}), port ? 32'd2 : 32'd1);
    check({tag, "_data"}, rsp_data, exp_d);
    check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_f));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int e0;
    logic g;

    // ---------------- reset ----------------
    rst = 1'b1;
    req0_valid = 1'b1;
    tick();
    tick();
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // ---------------- single add on port 0 ----------------
    e0 = en_cnt;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    check("add_req0_ready", 32'(req0_ready), 32'd1);
    check("add_req1_ready", 32'(req1_ready), 32'd0);
    tick();                                   // accept edge E0
    req0_valid = 1'b0;
    check("add_issue_en", 32'(alu_en), 32'd1);
    check("add_issue_op", 32'(alu_op), 32'h01);
    check("add_issue_a", alu_a, 32'd5);
    check("add_issue_b", alu_b, 32'd7);
    check("add_issue_busy", 32'(busy), 32'd1);
    check("add_issue_rsp0", 32'(rsp0_valid), 32'd0);
    tick();                                   // E1
    check("add_wait_en", 32'(alu_en), 32'd0);
    check("add_wait_rsp0", 32'(rsp0_valid), 32'd0);
    tick();                                   // E2
    check("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("add_data", rsp_data, 32'd12);
    check("add_flags", 32'(rsp_flags), 32'b001);
    check("add_err", 32'(rsp_err), 32'd0);
    tick();                                   // E3 handshake
    check("add_done_rsp0", 32'(rsp0_valid), 32'd0);
    check("add_done_busy", 32'(busy), 32'd0);
    check("add_en_pulses", 32'(en_cnt - e0), 32'd1);

    // ---------------- contention after a fresh reset ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 5'h03; req0_a = 32'd10;   req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 5'h0D; req1_a = 32'hF0;   req1_b = 32'h0F;
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!req0_ready && !req1_ready && n < 20) begin tick(); #1; n++; end
      if (i > 0) check("cont_gap", 32'(n), 32'd0);
      check("cont_grant", 32'({req0_ready, req1_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
      g = req1_ready;
      tick();
      n = 0;
      while (!rsp0_valid && !rsp1_valid && n < 40) begin tick(); n++; end
      check("cont_latency", 32'(n), 32'd2);
      check("cont_rsp_port", 32'({rsp1_valid, rsp0_valid}), g ? 32'd2 : 32'd1);
      check("cont_data", rsp_data, g ? 32'hFF : 32'd7);
      check("cont_flags", 32'(rsp_flags), 32'b010);
      tick();
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // ---------------- back-pressure on port 1 ----------------
    rsp0_ready = 1'b1;   // non-owner ready must be ignored
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 5'h05; req1_a = 32'd6; req1_b = 32'd7;
    #1;
    check("bp_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd1; req0_b = 32'd1;
    n = 0;
    while (!rsp1_valid && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("bp_data", rsp_data, 32'd42);
      check("bp_req0_ready", 32'(req0_ready), 32'd0);
      tick();
    end
    check("bp_flags", 32'(rsp_flags), 32'b001);
    check("bp_rsp0_valid", 32'(rsp0_valid), 32'd0);
    rsp1_ready = 1'b1;
    tick();
    #1;
    check("bp_after_req0_ready", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    tick();

    // ---------------- illegal opcode ----------------
    e0 = en_cnt;
    rsp0_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 5'h1F; req0_a = 32'd3; req0_b = 32'd4;
    tick();
    req0_valid = 1'b0;
    check("ill_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_data", rsp_data, 32'd0);
    check("ill_flags", 32'(rsp_flags), 32'd0);
    check("ill_alu_en", 32'(alu_en), 32'd0);
    tick();
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_no_en", 32'(en_cnt - e0), 32'd0);

    // opcode range edges
    run_op("op14", 1'b0, 5'h14, 32'd9, 32'd9, 32'd9, 3'b000, 1'b0);
    run_op("op15", 1'b1, 5'h15, 32'd9, 32'd9, 32'd0, 3'b000, 1'b1);
    run_op("op00", 1'b0, 5'h00, 32'd9, 32'd9, 32'd0, 3'b000, 1'b1);

    // ---------------- timeout ----------------
    alu_dead = 1'b1;
    req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd8; req0_b = 32'd1;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp0_valid && n < 60) begin tick(); n++; end
    check("tmo_latency", 32'(n), 32'd17);
    check("tmo_err", 32'(rsp_err), 32'd1);
    check("tmo_data", rsp_data, 32'd0);
    check("tmo_busy", 32'(busy), 32'd1);
    tick();
    check("tmo_idle", 32'(busy), 32'd0);

    // ---------------- flush in WAIT, stale valid ----------------
    req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd2; req0_b = 32'd2;
    tick();                 // ISSUE
    req0_valid = 1'b0;
    tick();                 // WAIT
    tick();                 // still WAIT
    check("fl_wait_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 32'(busy), 32'd0);
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fl_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      check("fl_idle", 32'(busy), 32'd0);
      tick();
    end
    alu_dead = 1'b0;
    run_op("fl_next", 1'b1, 5'h01, 32'd100, 32'd23, 32'd123, 3'b010, 1'b0);

    // flush while idle blocks acceptance
    req0_valid = 1'b1; req0_op = 5'h01;
    flush = 1'b1;
    #1;
    check("fl_idle_ready", 32'(req0_ready), 32'd0);
    tick();
    check("fl_idle_busy", 32'(busy), 32'd0);
    flush = 1'b0;
    req0_valid = 1'b0;

    // ---------------- async reset during RESP ----------------
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 5'h01; req0_a = 32'd1; req0_b = 32'd2;
    tick();
    n = 0;
    while (!rsp0_valid && n < 40) begin tick(); n++; end
    check("ar_pre_rsp0", 32'(rsp0_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_req0_ready", 32'(req0_ready), 32'd0);
    check("ar_rsp_data", rsp_data, 32'd0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    tick();
    run_op("ar_next", 1'b0, 5'h03, 32'd4, 32'd4, 32'd0, 3'b100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
